// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM encoding,
// protocol prefix bytes and the scan codes the game logic consumes.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXTEND = 8'hE0;

    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_J     = 8'h3B;
    localparam logic [7:0] KEY_L     = 8'h4B;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 clock and data lines, debounces the clock and
// emits a one-cycle strobe on each falling edge of the filtered clock.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clk_raw,
    input  logic data_raw,
    output logic data_sync,
    output logic clk_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    clk_meta;
    logic [1:0]    data_meta;
    logic [CW-1:0] run_cnt;
    logic          clk_filt;

    // NOTE: non-blocking assignments make both synchroniser stages and the
    // filter see the previous-cycle values, exactly like the flops they model.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta  <= 2'b11;
            data_meta <= 2'b11;
            run_cnt   <= '0;
            clk_filt  <= 1'b1;
            clk_fall  <= 1'b0;
        end else begin
            clk_meta  <= {clk_meta[0], clk_raw};
            data_meta <= {data_meta[0], data_raw};
            clk_fall  <= 1'b0;
            // Any sample agreeing with the current level restarts the run.
            if (clk_meta[1] == clk_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == LAST) begin
                clk_filt <= clk_meta[1];
                run_cnt  <= '0;
                clk_fall <= clk_filt;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

    assign data_sync = data_meta[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserialises device frames and tracks make/break
// codes. Optional macro PS2_REPEAT_FILTER_EN suppresses typematic repeats.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] tasta,
    output logic       done,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          strike;
    logic          data_s;
    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic          parity_q;
    logic [TW-1:0] idle_cnt_q;
    logic          timeout;
    logic          stop_strike;
    logic          frame_good;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [7:0]    tasta_d;
    logic          done_d, key_valid_d, frame_err_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clock     (clock),
        .reset     (reset),
        .clk_raw   (ps2_clk),
        .data_raw  (ps2_data),
        .data_sync (data_s),
        .clk_fall  (strike)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    assign timeout = (state_q != ST_IDLE) && !strike && (idle_cnt_q == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ST_IDLE;
        end else if (strike) begin
            unique case (state_q)
                ST_IDLE:   if (!data_s) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
            endcase
        end
    end

    // Idle counter is held at zero in IDLE so a finished timeout cannot re-fire.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            if (strike || state_q == ST_IDLE) idle_cnt_q <= '0;
            else                              idle_cnt_q <= idle_cnt_q + TW'(1);
            if (strike) begin
                unique case (state_q)
                    ST_IDLE:   bit_cnt_q <= '0;
                    ST_DATA: begin
                        shreg_q   <= {data_s, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    ST_PARITY: parity_q <= data_s;
                    ST_STOP:   ;
                endcase
            end
        end
    end

    assign stop_strike = strike && (state_q == ST_STOP);
    assign frame_good  = stop_strike && data_s && odd_parity_ok(shreg_q, parity_q);

    // NOTE: every signal gets its default before the branches, so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        tasta_d     = tasta;
        done_d      = done;
        brk_d       = brk_q;
        ext_d       = ext_q;
        key_valid_d = 1'b0;
        frame_err_d = stop_strike && !frame_good;
        if (frame_good) begin
            if (shreg_q == PS2_EXTEND) begin
                ext_d = 1'b1;
            end else if (shreg_q == PS2_BREAK) begin
                brk_d = 1'b1;
            end else if (!brk_q) begin
`ifdef PS2_REPEAT_FILTER_EN
                key_valid_d = !(done && shreg_q == tasta);
`else
                key_valid_d = 1'b1;
`endif
                tasta_d = shreg_q;
                done_d  = 1'b1;
                ext_d   = 1'b0;
            end else begin
                // Releasing some other key leaves the held key alone.
                if (shreg_q == tasta) done_d = 1'b0;
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tasta     <= 8'h00;
            done      <= 1'b0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
        end else begin
            tasta     <= tasta_d;
            done      <= done_d;
            key_valid <= key_valid_d;
            frame_err <= frame_err_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
        end
    end

endmodule
